// File: rtl/clust_pkg.sv
// rtl/clust_pkg.sv - shared defaults and FSM state encoding for the point frame transmitter
package clust_pkg;

    localparam int PT_W_DEF = 8;
    localparam int AW_DEF   = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEND     = 2'd1,
        ST_WAIT_RDY = 2'd2
    } state_t;

endpackage

// File: rtl/point_buf.sv
// rtl/point_buf.sv - simple dual-port point RAM, one write port, one registered read port
module point_buf
    import clust_pkg::*;
#(
    parameter int PT_W = PT_W_DEF,
    parameter int AW   = AW_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [2*PT_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [2*PT_W-1:0] rdata
);

    logic [2*PT_W-1:0] mem [2**AW];

    // No reset on the array: contents persist across frames and resets.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/point_frame_tx.sv
// rtl/point_frame_tx.sv - streams a buffered frame of points, then waits for downstream ready
module point_frame_tx
    import clust_pkg::*;
#(
    parameter int PT_W = PT_W_DEF,
    parameter int AW   = AW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [PT_W-1:0] wr_x,
    input  logic [PT_W-1:0] wr_y,
    input  logic [AW-1:0]   frame_len,
    input  logic            start,
    input  logic            ready_nd,
    output logic [PT_W-1:0] point_x,
    output logic [PT_W-1:0] point_y,
    output logic            valid_p,
    output logic            sop_p,
    output logic            eop_p,
    output logic            busy,
    output logic            done,
    output logic            err
);

    state_t state_q, state_d;

    logic [AW-1:0]     len_q;
    logic [AW-1:0]     idx_q;
    logic              issue_q;
    logic              s1_valid_q, s1_sop_q, s1_eop_q;
    logic              armed_q;
    logic [2*PT_W-1:0] rd_data;
    logic              start_ok;
    logic              last_issue;

    assign start_ok   = (state_q == ST_IDLE) && start && (frame_len != '0);
    assign last_issue = (idx_q == len_q - AW'(1));

    point_buf #(.PT_W(PT_W), .AW(AW)) u_buf (
        .clk   (clk),
        .we    (wr_en && (state_q == ST_IDLE)),
        .waddr (wr_addr),
        .wdata ({wr_x, wr_y}),
        .re    (issue_q),
        .raddr (idx_q),
        .rdata (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (start_ok) state_d = ST_SEND;
            ST_SEND:     if (valid_p && eop_p) state_d = ST_WAIT_RDY;
            ST_WAIT_RDY: if (armed_q && ready_nd) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != ST_IDLE);
    end

    // Read issue stage -> RAM/s1 stage -> output register: point 0 lands two cycles after start.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q      <= '0;
            idx_q      <= '0;
            issue_q    <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_sop_q   <= 1'b0;
            s1_eop_q   <= 1'b0;
            armed_q    <= 1'b0;
            valid_p    <= 1'b0;
            sop_p      <= 1'b0;
            eop_p      <= 1'b0;
            point_x    <= '0;
            point_y    <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            err  <= ((state_q == ST_IDLE) && start && (frame_len == '0))
                  || ((state_q != ST_IDLE) && (start || wr_en));
            done <= (state_q == ST_WAIT_RDY) && armed_q && ready_nd;

            // ready_nd is not trusted until one full WAIT_RDY cycle has passed.
            armed_q <= (state_q == ST_WAIT_RDY) && (state_d == ST_WAIT_RDY);

            if (start_ok) begin
                len_q   <= frame_len;
                idx_q   <= '0;
                issue_q <= 1'b1;
            end else if (issue_q) begin
                if (last_issue) begin
                    issue_q <= 1'b0;
                end else begin
                    idx_q <= idx_q + AW'(1);
                end
            end

            s1_valid_q <= issue_q;
            s1_sop_q   <= issue_q && (idx_q == '0);
            s1_eop_q   <= issue_q && last_issue;

            valid_p <= s1_valid_q;
            sop_p   <= s1_sop_q;
            eop_p   <= s1_eop_q;
            point_x <= s1_valid_q ? rd_data[2*PT_W-1:PT_W] : '0;
            point_y <= s1_valid_q ? rd_data[PT_W-1:0]      : '0;
        end
    end

endmodule

// File: tb/tb_point_frame_tx.sv
// tb/tb_point_frame_tx.sv - scoreboard bench for point_frame_tx
module tb_point_frame_tx;

    localparam int PT_W = 8;
    localparam int AW   = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [PT_W-1:0] wr_x, wr_y;
    logic [AW-1:0]   frame_len;
    logic            start;
    logic            ready_nd;
    logic [PT_W-1:0] point_x, point_y;
    logic            valid_p, sop_p, eop_p, busy, done, err;

    point_frame_tx #(.PT_W(PT_W), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_x      (wr_x),
        .wr_y      (wr_y),
        .frame_len (frame_len),
        .start     (start),
        .ready_nd  (ready_nd),
        .point_x   (point_x),
        .point_y   (point_y),
        .valid_p   (valid_p),
        .sop_p     (sop_p),
        .eop_p     (eop_p),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PT_W-1:0] x;
        logic [PT_W-1:0] y;
        logic            sop;
        logic            eop;
        int              cyc;
    } exp_t;

    exp_t            exp_q[$];
    logic [PT_W-1:0] mx [256];
    logic [PT_W-1:0] my [256];
    int              cyc = 0;
    int              last_eop_cyc = -100;
    int              n_cmp = 0;
    int              n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitor: pops one expected point per valid_p cycle, checks idle outputs otherwise.
    always @(negedge clk) begin
        if (valid_p) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 32'(point_x), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("point", {14'd0, point_x, point_y, sop_p, eop_p}, {14'd0, e.x, e.y, e.sop, e.eop});
                chk("point_cycle", 32'(cyc), 32'(e.cyc));
                if (eop_p) last_eop_cyc = cyc;
            end
        end else begin
            chk("idle_zero", {14'd0, sop_p, eop_p, point_x, point_y}, 32'd0);
        end
    end

    function automatic logic [PT_W-1:0] px(input int k);
        return PT_W'(k * 7 + 3);
    endfunction

    function automatic logic [PT_W-1:0] py(input int k);
        return PT_W'(200 - k * 5);
    endfunction

    task automatic load(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_addr = AW'(k); wr_x = px(k); wr_y = py(k);
            mx[k] = px(k); my[k] = py(k);
        end
        @(negedge clk);
        wr_en = 1'b0;
        chk("idle_write_err", 32'(err), 32'd0);
    endtask

    task automatic send(input int len, output int t);
        @(negedge clk);
        frame_len = AW'(len);
        start = 1'b1;
        t = cyc + 1;
        for (int k = 0; k < len; k++) begin
            exp_t e;
            e.x = mx[k]; e.y = my[k];
            e.sop = (k == 0); e.eop = (k == len - 1);
            e.cyc = t + 2 + k;
            exp_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int got;
        got = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                break;
            end
        end
        chk("done_seen", 32'(got), 32'd1);
        if (got == 1) begin
            chk("done_after_eop_ge2", 32'(cyc - last_eop_cyc >= 2), 32'd1);
            chk("busy_after_done", 32'(busy), 32'd0);
            @(negedge clk);
            chk("done_one_pulse", 32'(done), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_x = '0; wr_y = '0;
        frame_len = '0; start = 1'b0; ready_nd = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {26'd0, valid_p, sop_p, eop_p, busy, done, err}, 32'd0);
        chk("reset_point", {16'd0, point_x, point_y}, 32'd0);
        rst = 1'b0;

        load(21);

        // 21-point frame, ready_nd held high throughout
        ready_nd = 1'b1;
        send(21, t);
        chk("busy_in_send", 32'(busy), 32'd1);
        wait_done(40);
        chk("frame21_drained", 32'(exp_q.size()), 32'd0);

        // single-point frame, downstream not ready
        ready_nd = 1'b0;
        send(1, t);
        repeat (8) @(negedge clk);
        chk("wait_rdy_busy", 32'(busy), 32'd1);
        chk("wait_rdy_no_done", 32'(done), 32'd0);
        repeat (5) @(negedge clk);
        chk("wait_rdy_still_busy", 32'(busy), 32'd1);
        ready_nd = 1'b1;
        wait_done(10);

        // zero-length start is rejected
        @(negedge clk);
        frame_len = '0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("len0_err", 32'(err), 32'd1);
        chk("len0_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("len0_err_pulse", 32'(err), 32'd0);
        chk("len0_still_idle", 32'(busy), 32'd0);

        // start and write during SEND are dropped
        send(21, t);
        repeat (4) @(negedge clk);
        start = 1'b1; frame_len = AW'(5);
        wr_en = 1'b1; wr_addr = AW'(3); wr_x = 8'hEE; wr_y = 8'hEE;
        @(negedge clk);
        start = 1'b0; wr_en = 1'b0;
        chk("busy_start_wr_err", 32'(err), 32'd1);
        chk("busy_kept", 32'(busy), 32'd1);
        @(negedge clk);
        chk("busy_err_pulse", 32'(err), 32'd0);
        wait_done(40);

        // retransmit: buffer untouched by the dropped write
        send(21, t);
        wait_done(40);
        chk("retx_drained", 32'(exp_q.size()), 32'd0);

        // reset while point 10 is on the output
        send(21, t);
        repeat (12) @(negedge clk);
        chk("rst_at_point10", 32'(cyc), 32'(t + 12));
        rst = 1'b1;
        @(negedge clk);
        chk("rst_valid_low", 32'(valid_p), 32'd0);
        chk("rst_busy_low", 32'(busy), 32'd0);
        exp_q.delete();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        send(21, t);
        wait_done(40);
        chk("post_rst_drained", 32'(exp_q.size()), 32'd0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/point_frame_tx.md
POINT_FRAME_TX -- requirements
Module: point_frame_tx

Interface
REQ-001 SHALL have parameter PT_W, default 8, coordinate width of point_x/point_y.
REQ-002 SHALL have parameter AW, default 8, buffer address width; buffer depth 2^AW points.
REQ-003 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port wr_en  in  1  buffer write strobe.
REQ-006 SHALL have port wr_addr  in  AW  buffer write address, point index.
REQ-007 SHALL have port wr_x  in  PT_W  x coordinate to store.
REQ-008 SHALL have port wr_y  in  PT_W  y coordinate to store.
REQ-009 SHALL have port frame_len  in  AW  points per frame, sampled on accepted start.
REQ-010 SHALL have port start  in  1  frame transmit request, level-sampled.
REQ-011 SHALL have port ready_nd  in  1  downstream clustering engine done/ready for next frame.
REQ-012 SHALL have port point_x  out  PT_W  x coordinate of current point.
REQ-013 SHALL have port point_y  out  PT_W  y coordinate of current point.
REQ-014 SHALL have port valid_p  out  1  point_x/point_y valid.
REQ-015 SHALL have port sop_p  out  1  first point of frame, coincident with valid_p.
REQ-016 SHALL have port eop_p  out  1  last point of frame, coincident with valid_p.
REQ-017 SHALL have port busy  out  1  high in any state except IDLE.
REQ-018 SHALL have port done  out  1  one-cycle pulse when frame fully acknowledged.
REQ-019 SHALL have port err  out  1  one-cycle pulse on rejected start or rejected write.

Function
REQ-020 SHALL implement states IDLE, SEND, WAIT_RDY.
REQ-021 IDLE: start=1 with frame_len!=0 SHALL latch frame_len, clear read index, go SEND next cycle.
REQ-022 IDLE: start=1 with frame_len==0 SHALL pulse err next cycle and remain IDLE.
REQ-023 Start sampled at cycle t SHALL produce point 0 with valid_p=1, sop_p=1 at t+2 (one-cycle synchronous buffer read plus output register).
REQ-024 Point k SHALL appear at t+2+k with valid_p=1 every cycle; no gaps inside a frame.
REQ-025 eop_p SHALL be asserted with point frame_len-1; frame_len=1 SHALL assert sop_p and eop_p together.
REQ-026 valid_p, sop_p, eop_p SHALL be 0 outside the frame; point_x/point_y SHALL be 0 when valid_p=0.
REQ-027 After the eop_p cycle SHALL enter WAIT_RDY; ready_nd SHALL be ignored during the eop_p cycle and first WAIT_RDY cycle.
REQ-028 WAIT_RDY: ready_nd=1 sampled SHALL pulse done next cycle and return to IDLE.
REQ-029 start while busy=1 SHALL be ignored, pulse err, and not alter the frame in progress.
REQ-030 wr_en in IDLE SHALL write {wr_x,wr_y} to wr_addr; wr_en while busy=1 SHALL be dropped and pulse err.
REQ-031 Read index SHALL be AW bits; frame_len max 2^AW-1, no wrap inside a frame.
REQ-032 Buffer contents SHALL persist across frames; retransmitting without rewrite SHALL repeat identical data.

Reset
REQ-033 rst=1 SHALL force IDLE, all outputs 0, read index 0, latched length 0, on next edge.
REQ-034 rst mid-frame SHALL abort with no eop_p; buffer contents need not be cleared.

Structure
REQ-035 Package clust_pkg SHALL hold PT_W, AW defaults and the state encoding constants.
REQ-036 Sub-module point_buf SHALL implement a 2^AW x 2*PT_W simple dual-port RAM, synchronous read.

Verification
REQ-037 Load 21 points, frame_len=21, start -> valid_p 21 consecutive cycles from t+2, sop_p on index 0, eop_p on index 20, data matches buffer.
REQ-038 frame_len=1 -> single valid cycle with sop_p=eop_p=1, then WAIT_RDY.
REQ-039 frame_len=0 start -> err pulse, busy stays 0, no valid_p.
REQ-040 start and wr_en during SEND -> err pulses, frame unchanged, buffer unchanged.
REQ-041 ready_nd held 1 throughout -> done not before 2 cycles after eop_p; ready_nd held 0 -> stays WAIT_RDY, busy=1.
REQ-042 rst asserted at point 10 of 21 -> next cycle valid_p=0, busy=0; new start sends full 21-point frame.
